// File: rtl/sort4_sequencer.sv
// Four-element 3-bit bubble sorter with early exit, using one shared comparator.
// Each SORT cycle compares one adjacent register pair and swaps when the lower slot holds the larger value.
//
//   state | meaning
//   IDLE  | waiting for start; results held, valid stays set after a sort
//   SORT  | one adjacent compare (and optional swap) per cycle
//   DONE  | one-cycle completion pulse, then back to IDLE
module sort4_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] data_in,
   output logic [11:0] data_out,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic [2:0]  swap_count
);

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t          state;
   logic [3:0][2:0] r;
   logic [1:0]      idx;
   logic [1:0]      pass;
   logic            pass_swapped;

   logic [2:0] cmp_a;
   logic [2:0] cmp_b;
   logic       a_gt_b;
   logic       last_idx;

   // The only comparator in the block; equal elements are never swapped.
   assign cmp_a    = r[idx];
   assign cmp_b    = r[idx + 2'd1];
   assign a_gt_b   = cmp_a > cmp_b;
   assign last_idx = (idx == (2'd2 - pass));
   assign data_out = r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         r            <= '0;
         idx          <= '0;
         pass         <= '0;
         pass_swapped <= 1'b0;
         swap_count   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         valid        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r            <= data_in;
                  idx          <= '0;
                  pass         <= '0;
                  pass_swapped <= 1'b0;
                  swap_count   <= '0;
                  valid        <= 1'b0;
                  busy         <= 1'b1;
                  state        <= SORT;
               end
            end
            SORT: begin
               if (a_gt_b) begin
                  r[idx]         <= cmp_b;
                  r[idx + 2'd1]  <= cmp_a;
                  swap_count     <= swap_count + 3'd1;
               end
               if (last_idx) begin
                  // A clean pass means the array is ordered; pass 2 is always the last.
                  if (!(pass_swapped || a_gt_b) || pass == 2'd2) begin
                     done  <= 1'b1;
                     valid <= 1'b1;
                     state <= DONE;
                  end else begin
                     pass         <= pass + 2'd1;
                     idx          <= '0;
                     pass_swapped <= 1'b0;
                  end
               end else begin
                  idx          <= idx + 2'd1;
                  pass_swapped <= pass_swapped | a_gt_b;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sort4_sequencer.sv
// Bench for sort4_sequencer: an inversion-count model predicts result, swaps and latency,
// and a negedge compare process checks busy/done/valid/data every cycle.
module tb_sort4_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] data_in;
   logic [11:0] data_out;
   logic        busy;
   logic        done;
   logic        valid;
   logic [2:0]  swap_count;

   int n_cmp = 0;
   int n_err = 0;

   sort4_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .data_in    (data_in),
      .data_out   (data_out),
      .busy       (busy),
      .done       (done),
      .valid      (valid),
      .swap_count (swap_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sorted result by counting: emit every element of value 0, then 1, ... up to 7.
   function automatic logic [11:0] model_sorted(input logic [11:0] d);
      logic [11:0] res;
      int k;
      res = '0;
      k = 0;
      for (int v = 0; v < 8; v++)
         for (int i = 0; i < 4; i++)
            if (int'(d[3*i +: 3]) == v) begin
               res[3*k +: 3] = 3'(v);
               k++;
            end
      return res;
   endfunction

   // Adjacent-swap sorting performs exactly one swap per inverted pair.
   function automatic int model_swaps(input logic [11:0] d);
      int c;
      c = 0;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (d[3*i +: 3] > d[3*j +: 3]) c++;
      return c;
   endfunction

   // Passes needed = largest count of bigger elements left of any element, plus one clean pass (max 3).
   function automatic int model_compares(input logic [11:0] d);
      int lmax, c, passes;
      lmax = 0;
      for (int j = 0; j < 4; j++) begin
         c = 0;
         for (int i = 0; i < j; i++)
            if (d[3*i +: 3] > d[3*j +: 3]) c++;
         if (c > lmax) lmax = c;
      end
      passes = (lmax + 1 > 3) ? 3 : lmax + 1;
      return (passes == 1) ? 3 : (passes == 2) ? 5 : 6;
   endfunction

   logic        m_active = 1'b0;
   logic        m_valid  = 1'b0;
   logic        m_clear  = 1'b1;
   int          m_cyc    = 0;
   int          m_n      = 0;
   int          m_swaps  = 0;
   logic [11:0] m_sorted = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_valid  <= 1'b0;
         m_clear  <= 1'b1;
         m_cyc    <= 0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_cyc    <= 1;
            m_valid  <= 1'b0;
            m_clear  <= 1'b0;
            m_sorted <= model_sorted(data_in);
            m_swaps  <= model_swaps(data_in);
            m_n      <= model_compares(data_in);
         end
      end else if (m_cyc == m_n + 1) begin
         m_active <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_cyc == m_n) m_valid <= 1'b1;
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_active && m_cyc == m_n + 1));
      check("valid", 32'(valid), 32'(m_valid));
      if (m_valid) begin
         check("result", 32'(data_out), 32'(m_sorted));
         check("swaps", 32'(swap_count), 32'(m_swaps));
      end
      if (m_clear) begin
         check("clear_data", 32'(data_out), 32'h0);
         check("clear_swaps", 32'(swap_count), 32'h0);
      end
   end

   // Caller is positioned at a negedge; start is sampled at the next rising edge.
   task automatic run_sort(input logic [11:0] d, input logic [11:0] exp_out,
                           input int exp_sw, input int exp_n, input bit disturb);
      int cycles;
      start   = 1'b1;
      data_in = d;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      while (!done && cycles < 20) begin
         if (disturb) begin
            if (cycles == 2) begin
               start   = 1'b1;
               data_in = 12'o7777;
            end
            if (cycles == 4) start = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 32'h1);
      check("done_cycle", 32'(cycles), 32'(exp_n + 1));
      check("lit_out", 32'(data_out), 32'(exp_out));
      check("lit_swaps", 32'(swap_count), 32'(exp_sw));
      check("model_n", 32'(model_compares(d)), 32'(exp_n));
      check("model_out", 32'(model_sorted(d)), 32'(exp_out));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      repeat (2) @(negedge clk);
      check("rst_out", 32'(data_out), 32'h0);
      check("rst_flags", 32'({busy, done, valid}), 32'h0);
      rst = 1'b0;

      run_sort(12'o3210, 12'o3210, 0, 3, 1'b0);
      run_sort(12'o0123, 12'o3210, 6, 6, 1'b0);
      run_sort(12'o3201, 12'o3210, 1, 5, 1'b0);
      run_sort(12'o1717, 12'o7711, 3, 6, 1'b0);
      run_sort(12'o5555, 12'o5555, 0, 3, 1'b0);
      run_sort(12'o2461, 12'o6421, 3, 6, 1'b0);
      run_sort(12'o0123, 12'o3210, 6, 6, 1'b1);

      // Abort a sort with a mid-cycle reset.
      start   = 1'b1;
      data_in = 12'o0123;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_out", 32'(data_out), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_done", 32'(done), 32'h0);
      check("async_valid", 32'(valid), 32'h0);
      check("async_swaps", 32'(swap_count), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_sort(12'o1717, 12'o7711, 3, 6, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sort4_sequencer.md
SORT4_SEQUENCER -- requirements
Module: sort4_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, as fixed for this block.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to sort; sampled only in IDLE.
REQ-005 data_in  input  12  four 3-bit unsigned elements: e0=[2:0], e1=[5:3], e2=[8:6], e3=[11:9].
REQ-006 data_out  output  12  working/result registers R0..R3, same packing; ascending on completion (R0 smallest).
REQ-007 busy  output  1  high while in SORT or DONE.
REQ-008 done  output  1  one-cycle pulse in DONE state.
REQ-009 valid  output  1  high from DONE until next accepted start or reset.
REQ-010 swap_count  output  3  number of swaps performed in current/last sort (max 6).

Function
REQ-011 The block SHALL use exactly one shared 3-bit unsigned magnitude compare (greater/equal/less) per cycle; no other compare logic.
REQ-012 FSM states SHALL be IDLE, SORT, DONE; encoding free.
REQ-013 IDLE: start=1 at an edge -> load R0..R3 from data_in, idx=0, pass=0, pass_swapped=0, swap_count=0, valid=0, go SORT; start=0 -> stay.
REQ-014 SORT: each cycle compare R[idx] (A) with R[idx+1] (B); A>B -> swap both registers at edge, swap_count+1, pass_swapped=1; A<=B -> no swap (equal elements never swapped).
REQ-015 Pass p (0..2) SHALL compare idx = 0 .. 2-p (3, 2, 1 compares).
REQ-016 At last idx of pass: if no swap in the pass (including this compare) or p=2 -> go DONE; else p+1, idx=0, pass_swapped=0.
REQ-017 DONE: done=1 and valid=1 for one cycle, then IDLE; valid stays 1 in IDLE.
REQ-018 Latency: start sampled at edge E0; N compare cycles follow (3 <= N <= 6); done high in cycle N+1 after E0.
REQ-019 start while SORT or DONE SHALL be ignored (no reload, no queuing); data_in changes during SORT SHALL not affect result.
REQ-020 start in IDLE with valid=1 SHALL restart normally, clearing valid at the load edge.
REQ-021 data_out SHALL reflect R0..R3 at all times; only guaranteed sorted while valid=1.
REQ-022 swap_count SHALL never exceed 6; no wrap logic required.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, R0..R3=0, data_out=0, busy=0, done=0, valid=0, swap_count=0, idx=0, pass=0, regardless of state.
REQ-024 Reset during SORT SHALL abort the sort; after release block waits for a new start.
REQ-025 First start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-026 Sorted input data_in={3,2,1,0} (e3..e0) -> N=3, done in cycle 4, data_out=12'o3210, swap_count=0.
REQ-027 Reversed input e0..e3 = 3,2,1,0 -> N=6, done in cycle 7, data_out ascending e0..e3=0,1,2,3, swap_count=6.
REQ-028 Input e0..e3 = 1,0,2,3 -> one swap pass 0, clean pass 1, N=5, done in cycle 6, swap_count=1.
REQ-029 Duplicates e0..e3 = 7,1,7,1 -> result 1,1,7,7, swap_count=3; equal pairs never swapped.
REQ-030 start pulsed again and data_in changed mid-SORT -> ignored, result matches original data; then rst asserted mid-SORT -> all outputs 0 asynchronously, busy=0, next start sorts correctly.
